// File: rtl/filter_stream_engine.sv
// Purpose: 3x3 window filter (Sobel edge, enhance, boundary, dilation, threshold) over CHANNELS lanes.
// Latency: PIPE_STAGES cycles from window accept to pixel output while pix_ready stays high.
// Backpressure: pix_valid && !pix_ready freezes every stage together and drops win_ready.
// Optional build macro FILTER_STATS_EN adds per-channel stat_min/stat_max outputs.
module filter_stream_engine #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int CHANNELS     = 1,
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int PIPE_STAGES  = 2,
    localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT,
    localparam int CNT_W = $clog2(TOTAL + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [15:0]                     command,
    input  logic                            start,
    input  logic [PIXEL_WIDTH-1:0]          threshold,
    input  logic                            win_valid,
    output logic                            win_ready,
    input  logic [CHANNELS*9*PIXEL_WIDTH-1:0] win_data,
    output logic                            pix_valid,
    input  logic                            pix_ready,
    output logic [CHANNELS*PIXEL_WIDTH-1:0] pix_data,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [CNT_W-1:0]                pixel_count
`ifdef FILTER_STATS_EN
    ,
    output logic [CHANNELS*PIXEL_WIDTH-1:0] stat_min,
    output logic [CHANNELS*PIXEL_WIDTH-1:0] stat_max
`endif
);

    // Five extra bits cover the worst Sobel sum (|Gx|+|Gy| <= 8*max) with sign.
    localparam int IW = PIXEL_WIDTH + 5;
    localparam int DW = CHANNELS * PIXEL_WIDTH;
    localparam logic signed [IW-1:0] MAXV = IW'((1 << PIXEL_WIDTH) - 1);

    localparam logic [15:0] OP_EDGE     = 16'hA010;
    localparam logic [15:0] OP_ENHANCE  = 16'hA020;
    localparam logic [15:0] OP_BOUNDARY = 16'hA060;
    localparam logic [15:0] OP_DILATE   = 16'hA070;
    localparam logic [15:0] OP_THRESH   = 16'hA080;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state, state_nxt;
    logic [15:0]              cmd_q;
    logic [PIXEL_WIDTH-1:0]   thr_q;
    logic [CNT_W-1:0]         in_count;
    logic [PIPE_STAGES-1:0]   vld_q;
    logic [DW-1:0]            dat_q [PIPE_STAGES];
    logic [DW-1:0]            filt_dat;
    logic                     stalled, in_fire, out_fire, op_ok, start_ok, last_in, last_out;

    // One channel of the filter; all arithmetic is signed and saturated at the end.
    function automatic logic [PIXEL_WIDTH-1:0] filt_one(
        input logic [15:0]              op,
        input logic [PIXEL_WIDTH-1:0]   thr,
        input logic [9*PIXEL_WIDTH-1:0] w
    );
        logic signed [IW-1:0] p [9];
        logic signed [IW-1:0] gx, gy, res, mx, mn;
        for (int k = 0; k < 9; k++)
            p[k] = $signed({{(IW-PIXEL_WIDTH){1'b0}}, w[k*PIXEL_WIDTH +: PIXEL_WIDTH]});
        mx = p[0];
        mn = p[0];
        for (int k = 1; k < 9; k++) begin
            if (p[k] > mx) mx = p[k];
            if (p[k] < mn) mn = p[k];
        end
        gx = (p[2] + p[5] + p[5] + p[8]) - (p[0] + p[3] + p[3] + p[6]);
        gy = (p[6] + p[7] + p[7] + p[8]) - (p[0] + p[1] + p[1] + p[2]);
        if (gx[IW-1]) gx = -gx;
        if (gy[IW-1]) gy = -gy;
        case (op)
            OP_EDGE:     res = gx + gy;
            OP_ENHANCE:  res = p[4] + p[4] + p[4] + p[4] + p[4] - p[1] - p[3] - p[5] - p[7];
            OP_BOUNDARY: res = p[4] - mn;
            OP_DILATE:   res = mx;
            OP_THRESH:   res = (w[4*PIXEL_WIDTH +: PIXEL_WIDTH] >= thr) ? MAXV : '0;
            default:     res = '0;
        endcase
        if (res[IW-1])
            return '0;
        else if (res > MAXV)
            return '1;
        else
            return res[PIXEL_WIDTH-1:0];
    endfunction

    assign pix_valid = vld_q[PIPE_STAGES-1];
    assign pix_data  = dat_q[PIPE_STAGES-1];
    assign stalled   = pix_valid && !pix_ready;
    assign win_ready = (state == RUN) && !stalled;
    assign in_fire   = win_valid && win_ready;
    assign out_fire  = pix_valid && pix_ready;
    assign op_ok     = (command == OP_EDGE) || (command == OP_ENHANCE) || (command == OP_BOUNDARY)
                    || (command == OP_DILATE) || (command == OP_THRESH);
    assign start_ok  = (state == IDLE) && start && op_ok;
    assign last_in   = in_fire && (in_count == CNT_W'(TOTAL - 1));
    assign last_out  = out_fire && (pixel_count == CNT_W'(TOTAL - 1));
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);

    // Filter every channel of the presented window with the latched opcode.
    always_comb begin
        filt_dat = '0;
        for (int c = 0; c < CHANNELS; c++)
            filt_dat[c*PIXEL_WIDTH +: PIXEL_WIDTH] =
                filt_one(cmd_q, thr_q, win_data[c*9*PIXEL_WIDTH +: 9*PIXEL_WIDTH]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Frame sequencing: run until all windows are in, drain until all pixels are out.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_ok) state_nxt = RUN;
            RUN:   if (last_in)  state_nxt = DRAIN;
            DRAIN: if (last_out) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pipeline shift; a stall holds all stages so nothing is dropped or repeated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) dat_q[i] <= '0;
        end else if (!stalled) begin
            vld_q[0] <= in_fire;
            dat_q[0] <= filt_dat;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    // Command latch, transfer counters and the bad-opcode error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q       <= '0;
            thr_q       <= '0;
            in_count    <= '0;
            pixel_count <= '0;
            error       <= 1'b0;
        end else begin
            error <= (state == IDLE) && start && !op_ok;
            if (start_ok) begin
                cmd_q       <= command;
                thr_q       <= threshold;
                in_count    <= '0;
                pixel_count <= '0;
            end else begin
                if (in_fire)  in_count    <= in_count + CNT_W'(1);
                if (out_fire) pixel_count <= pixel_count + CNT_W'(1);
            end
        end
    end

`ifdef FILTER_STATS_EN
    // Per-channel running min/max of delivered pixels, restarted with each frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_min <= '1;
            stat_max <= '0;
        end else if (start_ok) begin
            stat_min <= '1;
            stat_max <= '0;
        end else if (out_fire) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (pix_data[c*PIXEL_WIDTH +: PIXEL_WIDTH] < stat_min[c*PIXEL_WIDTH +: PIXEL_WIDTH])
                    stat_min[c*PIXEL_WIDTH +: PIXEL_WIDTH] <= pix_data[c*PIXEL_WIDTH +: PIXEL_WIDTH];
                if (pix_data[c*PIXEL_WIDTH +: PIXEL_WIDTH] > stat_max[c*PIXEL_WIDTH +: PIXEL_WIDTH])
                    stat_max[c*PIXEL_WIDTH +: PIXEL_WIDTH] <= pix_data[c*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end
`endif

endmodule

// File: tb/tb_filter_stream_engine.sv
// Purpose: randomized and directed checks of filter_stream_engine against an integer reference model.
// Latency: expects outputs PS cycles after accept when no backpressure is applied.
// Backpressure: pix_ready is randomized in selected frames; holds and win_ready are checked each stall.
module tb_filter_stream_engine;

    localparam int PW    = 8;
    localparam int CH    = 2;
    localparam int IMW   = 4;
    localparam int IMH   = 2;
    localparam int PS    = 2;
    localparam int TOTAL = IMW * IMH;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int WD    = CH * 9 * PW;
    localparam int DW    = CH * PW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [15:0]     command = '0;
    logic            start = 1'b0;
    logic [PW-1:0]   threshold = '0;
    logic            win_valid = 1'b0;
    logic            win_ready;
    logic [WD-1:0]   win_data = '0;
    logic            pix_valid;
    logic            pix_ready = 1'b1;
    logic [DW-1:0]   pix_data;
    logic            busy, done, error;
    logic [CW-1:0]   pixel_count;
`ifdef FILTER_STATS_EN
    logic [DW-1:0]   stat_min, stat_max;
`endif

    filter_stream_engine #(
        .PIXEL_WIDTH(PW), .CHANNELS(CH), .IMAGE_WIDTH(IMW), .IMAGE_HEIGHT(IMH), .PIPE_STAGES(PS)
    ) dut (
        .clk(clk), .rst(rst), .command(command), .start(start), .threshold(threshold),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .busy(busy), .done(done), .error(error), .pixel_count(pixel_count)
`ifdef FILTER_STATS_EN
        , .stat_min(stat_min), .stat_max(stat_max)
`endif
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            err_cnt = 0;
    int            out_cnt = 0;
    bit            bp = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    logic [15:0]   m_op = '0;
    logic [7:0]    m_thr = '0;
    logic [DW-1:0] exp_q [$];
    int            lat_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each filter written directly from its arithmetic definition on ints.
    function automatic logic [DW-1:0] ref_win(input logic [WD-1:0] wd);
        logic [DW-1:0] r;
        int p [9];
        int gx, gy, v, mn, mx;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < 9; k++) p[k] = int'(wd[(c*9+k)*PW +: PW]);
            mn = 255; mx = 0;
            for (int k = 0; k < 9; k++) begin
                if (p[k] < mn) mn = p[k];
                if (p[k] > mx) mx = p[k];
            end
            gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
            gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
            if (gx < 0) gx = -gx;
            if (gy < 0) gy = -gy;
            case (m_op)
                16'hA010: v = gx + gy;
                16'hA020: v = 5*p[4] - p[1] - p[3] - p[5] - p[7];
                16'hA060: v = p[4] - mn;
                16'hA070: v = mx;
                16'hA080: v = (p[4] >= int'(m_thr)) ? 255 : 0;
                default:  v = 0;
            endcase
            if (v < 0)   v = 0;
            if (v > 255) v = 255;
            r[c*PW +: PW] = 8'(v);
        end
        return r;
    endfunction

    // Window generator: mode 0 random, 1 threshold centres, 2 edge corners, 3 enhance extremes.
    function automatic logic [WD-1:0] make_win(input int mode, input int n);
        logic [WD-1:0] w;
        logic [7:0]    cen [4];
        int            s;
        cen = '{8'h7F, 8'h80, 8'h00, 8'hFF};
        for (int c = 0; c < CH; c++) begin
            s = (n + c) % 4;
            for (int k = 0; k < 9; k++) w[(c*9+k)*PW +: PW] = 8'($urandom);
            case (mode)
                1: w[(c*9+4)*PW +: PW] = cen[s];
                2: if (s == 0) begin
                       for (int k = 0; k < 9; k++) w[(c*9+k)*PW +: PW] = (k % 3 == 0) ? 8'hFF : 8'h00;
                   end else if (s == 1) begin
                       for (int k = 0; k < 9; k++) w[(c*9+k)*PW +: PW] = 8'h40;
                   end
                3: if (s == 0) begin
                       for (int k = 0; k < 9; k++) w[(c*9+k)*PW +: PW] = (k == 4) ? 8'h00 : 8'hFF;
                   end else if (s == 1) begin
                       for (int k = 0; k < 9; k++) w[(c*9+k)*PW +: PW] = (k == 4) ? 8'hFF : 8'h00;
                   end
                default: ;
            endcase
        end
        return w;
    endfunction

    // One clock: observe at negedge, then drive new inputs 1 time unit after posedge.
    task automatic tick(output bit in_xfer);
        logic [DW-1:0] e;
        int            t;
        @(negedge clk);
        in_xfer = win_valid && win_ready;
        if (in_xfer) begin
            exp_q.push_back(ref_win(win_data));
            lat_q.push_back(cyc);
        end
        if (prev_stall) begin
            check("hold_valid", pix_valid, 1);
            check("hold_data", pix_data, prev_dat);
        end
        if (pix_valid && !pix_ready) check("win_ready_in_stall", win_ready, 0);
        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", pix_valid, 0);
            end else begin
                e = exp_q.pop_front();
                t = lat_q.pop_front();
                check("pix_data", pix_data, e);
                if (!bp) check("latency", cyc - t, PS);
            end
            out_cnt++;
        end
        if (done)  done_cnt++;
        if (error) err_cnt++;
        prev_stall = pix_valid && !pix_ready;
        prev_dat   = pix_data;
        @(posedge clk);
        #1;
        cyc++;
        if (bp) pix_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_win_ready"}, win_ready, 0);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_pix_data"}, pix_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_pixel_count"}, pixel_count, 0);
    endtask

    task automatic run_frame(input logic [15:0] op, input logic [7:0] thr, input int mode,
                             input bit bpe, input bit gaps, input bit poke, input int abort_at);
        bit x;
        int n, budget, e0;
        bp = bpe;
        if (!bpe) pix_ready = 1'b1;
        done_cnt = 0; out_cnt = 0; e0 = err_cnt;
        m_op = op; m_thr = thr;
        command = op; threshold = thr; start = 1'b1; win_valid = 1'b0;
        tick(x);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        n = 0;
        while (n < TOTAL) begin
            if (n == abort_at) begin
                win_valid = 1'b0;
                return;
            end
            win_data = make_win(mode, n);
            budget = 0; x = 1'b0;
            while (!x && budget < 100) begin
                win_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (poke && n == 3) begin
                    command = 16'hA070;
                    start   = 1'b1;
                end
                tick(x);
                start = 1'b0;
                budget++;
            end
            if (!x) begin
                check("win_accept", x, 1);
                win_valid = 1'b0;
                return;
            end
            n++;
        end
        win_valid = 1'b0;
        budget = 0;
        while (done_cnt == 0 && budget < 300) begin
            tick(x);
            budget++;
        end
        tick(x);
        tick(x);
        check("done_once", done_cnt, 1);
        check("pixel_count", pixel_count, TOTAL);
        check("out_count", out_cnt, TOTAL);
        check("busy_after_done", busy, 0);
        check("queue_empty", exp_q.size(), 0);
        check("no_error_in_frame", err_cnt - e0, 0);
    endtask

    initial begin
        bit             x;
        int             e0;
        logic [15:0]    bad_ops [4];
        logic [15:0]    ops [5];
        bad_ops = '{16'hA030, 16'hA040, 16'hA050, 16'h0000};
        ops     = '{16'hA010, 16'hA020, 16'hA060, 16'hA070, 16'hA080};

        // Reset state.
        tick(x); tick(x); tick(x);
        check_reset("reset");

        // Release and start on the very next cycle: threshold frame.
        rst = 1'b1;
        run_frame(16'hA080, 8'h80, 1, 1'b0, 1'b0, 1'b0, -1);

        // Edge saturation and flat window.
        run_frame(16'hA010, 8'h00, 2, 1'b0, 1'b0, 1'b0, -1);

        // Enhance clamping at both rails.
        run_frame(16'hA020, 8'h00, 3, 1'b0, 1'b0, 1'b0, -1);

        // Unsupported opcodes pulse error once and stay idle.
        for (int i = 0; i < 4; i++) begin
            e0 = err_cnt;
            command = bad_ops[i]; start = 1'b1;
            tick(x);
            start = 1'b0;
            check("busy_bad_op", busy, 0);
            tick(x);
            tick(x);
            check("error_pulse", err_cnt - e0, 1);
            check("still_idle", busy, 0);
        end

        // Boundary frame with backpressure; a start of A070 mid-frame must be ignored.
        run_frame(16'hA060, 8'h00, 0, 1'b1, 1'b0, 1'b1, -1);

        // Random frames with random backpressure and input gaps.
        for (int i = 0; i < 12; i++)
            run_frame(ops[$urandom_range(0, 4)], 8'($urandom), 0, 1'b1, 1'b1, 1'b0, -1);

        // Reset mid-frame aborts; the next frame runs to completion.
        run_frame(16'hA070, 8'h00, 0, 1'b1, 1'b0, 1'b0, 5);
        rst = 1'b0;
        #1;
        check_reset("midreset");
        exp_q.delete();
        lat_q.delete();
        prev_stall = 1'b0;
        done_cnt = 0;
        tick(x);
        tick(x);
        check("no_done_after_abort", done_cnt, 0);
        rst = 1'b1;
        run_frame(16'hA070, 8'h00, 0, 1'b1, 1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_stream_engine.md
FILTER_STREAM_ENGINE -- requirements
Module: filter_stream_engine

Interface
REQ-001 The block SHALL have parameter PIXEL_WIDTH, default 8, bits per channel sample.
REQ-002 The block SHALL have parameter CHANNELS, default 1, independent channels filtered in lockstep.
REQ-003 The block SHALL have parameters IMAGE_WIDTH and IMAGE_HEIGHT, defaults 320 and 240, frame size in pixels.
REQ-004 The block SHALL have parameter PIPE_STAGES, default 2, range 1..4, input-to-output latency in cycles.
REQ-005 Port clk, input, 1 bit: the single clock. The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-007 Ports command (input, 16) and start (input, 1): the filter opcode, sampled on a start pulse.
REQ-008 Port threshold, input, PIXEL_WIDTH: the binarisation level, sampled with command.
REQ-009 Ports win_valid (in, 1), win_ready (out, 1), win_data (in, CHANNELS*9*PIXEL_WIDTH): the 3x3 window stream; element k of channel c is at [(c*9+k)*PIXEL_WIDTH +: PIXEL_WIDTH], k=4 is the centre, row-major.
REQ-010 Ports pix_valid (out, 1), pix_ready (in, 1), pix_data (out, CHANNELS*PIXEL_WIDTH): the filtered pixel stream.
REQ-011 Ports busy (out, 1), done (out, 1), error (out, 1), pixel_count (out, clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1)): the status outputs.

Function
REQ-012 Opcodes: A010 edge = sat(|Gx|+|Gy|) Sobel; A020 enhance = sat(5*c - N - S - E - W) signed, clamped to 0..max; A060 boundary = c - min(9); A070 dilation = max(9); A080 threshold = (c >= threshold) ? max : 0.
REQ-013 Intermediate arithmetic SHALL use at least PIXEL_WIDTH+4 signed bits; the result SHALL saturate to [0, 2^PIXEL_WIDTH-1], with no wrap.
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-015 In IDLE with start=1 and a supported opcode, the block SHALL latch command and threshold, clear pixel_count and go to RUN.
REQ-016 In IDLE with start=1 and any other opcode (including A030, A040, A050), the block SHALL pulse error for 1 cycle and remain in IDLE.
REQ-017 start outside IDLE SHALL be ignored; the latched command SHALL NOT change mid-frame.
REQ-018 A window transfer SHALL occur when win_valid && win_ready; an output transfer SHALL occur when pix_valid && pix_ready.
REQ-019 win_ready SHALL equal (state==RUN) && (pipeline not stalled), where stalled = pix_valid && !pix_ready.
REQ-020 The pipeline SHALL stall every stage together; no data SHALL be lost or duplicated under backpressure.
REQ-021 With no stall, a window accepted at cycle t SHALL appear on pix_data with pix_valid at t+PIPE_STAGES.
REQ-022 pix_data and pix_valid SHALL hold stable while pix_valid && !pix_ready.
REQ-023 pixel_count SHALL increment on each output transfer.
REQ-024 After IMAGE_WIDTH*IMAGE_HEIGHT input transfers the FSM SHALL go to DRAIN, and win_ready SHALL deassert in that same cycle.
REQ-025 DRAIN SHALL go to DONE on the output transfer that makes pixel_count reach IMAGE_WIDTH*IMAGE_HEIGHT.
REQ-026 DONE SHALL assert done for exactly 1 cycle and then return to IDLE.
REQ-027 busy SHALL be 1 in RUN and DRAIN and 0 otherwise.
REQ-028 Channels SHALL be computed identically and independently; channel c output is at pix_data[c*PIXEL_WIDTH +: PIXEL_WIDTH].

Reset
REQ-029 While rst=0: state=IDLE, win_ready=0, pix_valid=0, pix_data=0, busy=0, done=0, error=0, pixel_count=0, and all pipeline valid bits cleared.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately; no done is produced and in-flight pixels are discarded.
REQ-031 Release of rst SHALL take effect on the next clk edge; the first start SHALL be accepted on the first cycle after release.

Configuration
REQ-032 With FILTER_STATS_EN defined, the block SHALL add outputs stat_min and stat_max (CHANNELS*PIXEL_WIDTH each), tracking the per-channel min and max of output pixels.
REQ-033 Under FILTER_STATS_EN, stat_min and stat_max SHALL be set to all-ones and zero respectively on frame start and on reset, update on each output transfer, and hold after done.
REQ-034 Without FILTER_STATS_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-035 Threshold: A080, threshold=0x80, 4x2 frame with centres 0x7F,0x80,0x00,0xFF -> outputs 0x00,0xFF,0x00,0xFF; done pulses once; pixel_count=8.
REQ-036 Edge saturation: A010 with left column 0xFF and rest 0x00 -> 0xFF with no wrap; flat window 0x40 -> 0x00.
REQ-037 Enhance clamping: A020 with c=0x00 and neighbours 0xFF -> 0x00; c=0xFF and neighbours 0x00 -> 0xFF.
REQ-038 Backpressure: pix_ready toggled pseudo-randomly (50%) over a 320x240 frame -> output sequence identical to a reference model, 76800 outputs, win_ready=0 whenever stalled.
REQ-039 Command errors: start with A030 -> error=1 for 1 cycle, busy stays 0; start with A070 during RUN -> ignored.
REQ-040 Reset mid-frame: rst=0 at pixel 100 -> all outputs reset; a following A070 frame completes normally with pixel_count=76800.
